local_net_interface: RTL and testbench
======================================

Name: local_net_interface

Overview:
- Per-node network interface between a processing core and the LOCAL port of a 2x4 mesh router.
- Injection path: converts core data beats into 32-bit flits. Every flit carries the destination in bits [2:0], because the router routes each flit independently.
- Writes flits into the router local input FIFO under LOCAL full backpressure.
- Ejection path: accepts every flit from the router local output, which has no backpressure. Checks address and per-source framing, then buffers flits for the core.

Parameters:
- NODE_ADDRESS, 3'd1, address of the attached router; also stamped as the source field.
- MAX_LEN, 16, maximum flits per packet (2..255).
- RX_DEPTH, 4, ejection FIFO depth (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tx_valid  in  1  core beat valid
- tx_ready  out  1  interface can accept the beat
- tx_dst  in  3  destination; sampled on the first beat of a packet only
- tx_data  in  24  payload
- tx_last  in  1  last beat of the packet
- NI_DATA_OUT  out  32  flit to router LOCAL_DATA_IN
- NI_DATA_VALID_OUT  out  1  to router LOCAL_DATA_VALID_IN
- NI_FULL_IN  in  1  from router LOCAL_FULL_OUT
- NI_DATA_IN  in  32  from router LOCAL_DATA_OUT
- NI_DATA_VALID_IN  in  1  from router LOCAL_DATA_VALID_OUT
- rx_valid  out  1  ejected flit available
- rx_ready  in  1  core pops the flit
- rx_data  out  24  payload
- rx_src  out  3  source address
- rx_type  out  2  flit type
- tx_len_err  out  1  sticky: packet truncated at MAX_LEN
- rx_ovf  out  1  sticky: ejection flit dropped because the FIFO was full
- tx_pkt_cnt  out  16  packets injected
- rx_pkt_cnt  out  16  packets completed
- rx_err_cnt  out  16  address or framing errors

Behaviour:
- Flit format: [2:0] dst, [5:3] src, [7:6] type, [31:8] payload.
  - Type encoding: 00 BODY, 01 HEAD, 10 TAIL, 11 SINGLE.
- Reset (synchronous, all sampled at posedge clk with rst=1): every output register, status flag and counter goes to 0; tx FSM to T_IDLE; all rx framing bits to 0; FIFO emptied. A packet in flight at reset is abandoned.
- Reset output values: NI_DATA_OUT=0, NI_DATA_VALID_OUT=0, rx_valid=0, all flags and counters 0.

TX path, one-entry hold register (hold_vld, hold_flit):
- tx_ready = !rst && (!hold_vld || !NI_FULL_IN).
- NI_DATA_VALID_OUT = hold_vld && !NI_FULL_IN, combinational. The flit is consumed in that same cycle.
- NI_DATA_OUT = hold_flit while hold_vld; 0 otherwise.
- A beat accepted in cycle t appears on NI_DATA_VALID_OUT at t+1 if NI_FULL_IN=0.
- Throughput: 1 flit per cycle.
- While NI_FULL_IN=1 the hold register keeps its flit.

TX FSM:
- T_IDLE, on an accepted beat:
  - tx_last=1: SINGLE flit, tx_pkt_cnt+1, stay in T_IDLE.
  - otherwise: HEAD flit; latch tx_dst; beat count = 1; go to T_PKT.
- T_PKT, on an accepted beat:
  - The latched dst is used; tx_dst is ignored.
  - tx_last=1, or beat count reaches MAX_LEN: TAIL flit, tx_pkt_cnt+1, go to T_IDLE.
  - Reaching MAX_LEN with tx_last=0 also sets tx_len_err. The next beat starts a new packet.
  - otherwise: BODY flit; beat count +1.
- The src field is always NODE_ADDRESS.

RX path, sampled when NI_DATA_VALID_IN=1; nothing is ever back-pressured:
- Address check: if flit dst != NODE_ADDRESS, the flit is dropped and rx_err_cnt+1. Framing state is unchanged.
- Framing uses an 8-bit in_pkt vector indexed by the src field, because flits from different sources interleave.
  - HEAD: if in_pkt[src] is already set, this is an error; in either case set in_pkt[src].
  - BODY: error if in_pkt[src]=0.
  - TAIL: if in_pkt[src]=1, clear it and rx_pkt_cnt+1; otherwise error.
  - SINGLE: error if in_pkt[src]=1; otherwise rx_pkt_cnt+1. In_pkt[src] is left unchanged.
  - A framing error increments rx_err_cnt, but the flit is still pushed.
- Ejection FIFO:
  - Push when the flit is accepted and (FIFO not full, or a pop occurs in the same cycle).
  - Full with no pop: flit dropped, rx_ovf set; the framing update still applies.
  - Pop when rx_valid && rx_ready.
  - rx_valid = FIFO not empty. rx_data, rx_src and rx_type show the head entry.
  - Latency: NI_DATA_VALID_IN at t gives rx_valid at t+1 (from empty).
- All counters saturate at 16'hFFFF.

Optional Feature:
- LOCAL_NI_STATS_EN defined: tx_pkt_cnt, rx_pkt_cnt and rx_err_cnt are implemented as described.
- Not defined:
  - The three counters are tied to 0 and their registers are removed.
  - tx_len_err, rx_ovf and the drop/framing behaviour are unchanged.

Test Plan:
- Reset, then a single beat with tx_dst=5, tx_data=24'hABCDEF, tx_last=1 -> next cycle NI_DATA_VALID_OUT=1 with NI_DATA_OUT=32'hABCDEF_C D (type 11, src 1, dst 5); tx_pkt_cnt=1.
- 4-beat packet to dst 2 while NI_FULL_IN=1 for cycles 2-4:
  - tx_ready=0 while the hold register is stalled.
  - Flit types 01,00,00,10 emitted in order; no loss or duplication.
- 20 beats with tx_last=0 and MAX_LEN=16 -> flit 16 is TAIL; tx_len_err=1; flit 17 is HEAD.
- Interleaved inbound HEAD(src2), HEAD(src6), TAIL(src2), TAIL(src6) to node 1 -> rx_pkt_cnt=2, rx_err_cnt=0.
- Inbound flit with dst=3 at node 1 -> not pushed; rx_err_cnt=1. Inbound BODY from an idle src -> pushed; rx_err_cnt=2.
- rx_ready=0 and 6 consecutive inbound SINGLE flits with RX_DEPTH=4 -> 4 buffered, rx_ovf=1; then with rx_ready=1 the 4 flits pop in order.

Source files
------------

// File: rtl/local_net_interface.sv
// rtl/local_net_interface.sv - core-to-router LOCAL port network interface; LOCAL_NI_STATS_EN enables packet/error counters
module local_net_interface #(
    parameter logic [2:0] NODE_ADDRESS = 3'd1,
    parameter int         MAX_LEN      = 16,
    parameter int         RX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [2:0]  tx_dst,
    input  logic [23:0] tx_data,
    input  logic        tx_last,
    output logic [31:0] NI_DATA_OUT,
    output logic        NI_DATA_VALID_OUT,
    input  logic        NI_FULL_IN,
    input  logic [31:0] NI_DATA_IN,
    input  logic        NI_DATA_VALID_IN,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [23:0] rx_data,
    output logic [2:0]  rx_src,
    output logic [1:0]  rx_type,
    output logic        tx_len_err,
    output logic        rx_ovf,
    output logic [15:0] tx_pkt_cnt,
    output logic [15:0] rx_pkt_cnt,
    output logic [15:0] rx_err_cnt
);
    localparam int         AW        = $clog2(RX_DEPTH);
    localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);
    localparam logic [1:0] TY_BODY = 2'b00, TY_HEAD = 2'b01, TY_TAIL = 2'b10, TY_SINGLE = 2'b11;

    typedef enum logic {T_IDLE, T_PKT} tx_state_t;
    tx_state_t   state_q, state_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [2:0]  dst_q, dst_d;
    logic        hold_vld_q, hold_vld_d;
    logic [31:0] hold_flit_q, hold_flit_d;
    logic        tx_len_err_q;
    logic        tx_accept, at_max, tx_pkt_done, len_err_set;
    logic [1:0]  flit_type;
    logic [2:0]  flit_dst;

    assign tx_ready          = !rst && (!hold_vld_q || !NI_FULL_IN);
    assign tx_accept         = tx_valid && tx_ready;
    assign NI_DATA_VALID_OUT = hold_vld_q && !NI_FULL_IN;
    assign NI_DATA_OUT       = hold_vld_q ? hold_flit_q : 32'd0;
    assign at_max            = (beat_cnt_q + 8'd1) == MAX_LEN_C;
    assign tx_len_err        = tx_len_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= T_IDLE;
            beat_cnt_q <= 8'd0;
            dst_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            dst_q      <= dst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        dst_d      = dst_q;
        if (tx_accept) begin
            case (state_q)
                T_IDLE: if (!tx_last) begin
                    state_d    = T_PKT;
                    dst_d      = tx_dst;
                    beat_cnt_d = 8'd1;
                end
                T_PKT: if (tx_last || at_max) state_d = T_IDLE;
                       else beat_cnt_d = beat_cnt_q + 8'd1;
                default: state_d = T_IDLE;
            endcase
        end
    end

    always_comb begin
        flit_type   = TY_BODY;
        flit_dst    = (state_q == T_PKT) ? dst_q : tx_dst;
        tx_pkt_done = 1'b0;
        len_err_set = 1'b0;
        if (state_q == T_IDLE) begin
            flit_type   = tx_last ? TY_SINGLE : TY_HEAD;
            tx_pkt_done = tx_accept && tx_last;
        end else if (tx_last || at_max) begin
            flit_type   = TY_TAIL;
            tx_pkt_done = tx_accept;
            len_err_set = tx_accept && !tx_last;
        end
    end

    // A flit leaves the hold register whenever the router is not full
    always_comb begin
        hold_vld_d  = hold_vld_q && NI_FULL_IN;
        hold_flit_d = hold_flit_q;
        if (tx_accept) begin
            hold_vld_d  = 1'b1;
            hold_flit_d = {tx_data, flit_type, NODE_ADDRESS, flit_dst};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_q   <= 1'b0;
            hold_flit_q  <= 32'd0;
            tx_len_err_q <= 1'b0;
        end else begin
            hold_vld_q   <= hold_vld_d;
            hold_flit_q  <= hold_flit_d;
            tx_len_err_q <= tx_len_err_q || len_err_set;
        end
    end

    logic [2:0]  in_dst, in_src;
    logic [1:0]  in_type;
    logic        addr_ok, frame_err, rx_pkt_done, rx_err;
    logic [7:0]  in_pkt_q, in_pkt_d;
    logic [28:0] mem_q [RX_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic        fifo_full, push, pop, rx_ovf_q;

    assign in_dst  = NI_DATA_IN[2:0];
    assign in_src  = NI_DATA_IN[5:3];
    assign in_type = NI_DATA_IN[7:6];
    assign addr_ok = NI_DATA_VALID_IN && (in_dst == NODE_ADDRESS);

    // Per-source open-packet bits: sources interleave at the ejection port
    always_comb begin
        in_pkt_d    = in_pkt_q;
        frame_err   = 1'b0;
        rx_pkt_done = 1'b0;
        if (addr_ok) begin
            case (in_type)
                TY_HEAD: begin
                    frame_err        = in_pkt_q[in_src];
                    in_pkt_d[in_src] = 1'b1;
                end
                TY_BODY: frame_err = !in_pkt_q[in_src];
                TY_TAIL: begin
                    if (in_pkt_q[in_src]) begin
                        in_pkt_d[in_src] = 1'b0;
                        rx_pkt_done      = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: begin
                    frame_err   = in_pkt_q[in_src];
                    rx_pkt_done = !in_pkt_q[in_src];
                end
            endcase
        end
    end

    assign rx_err    = NI_DATA_VALID_IN && (!addr_ok || frame_err);
    assign fifo_full = count_q == (AW+1)'(RX_DEPTH);
    assign rx_valid  = count_q != '0;
    assign pop       = rx_valid && rx_ready;
    assign push      = addr_ok && (!fifo_full || pop);
    assign rx_data   = mem_q[rd_ptr_q][28:5];
    assign rx_src    = mem_q[rd_ptr_q][4:2];
    assign rx_type   = mem_q[rd_ptr_q][1:0];
    assign rx_ovf    = rx_ovf_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {NI_DATA_IN[31:8], in_src, in_type};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_pkt_q <= 8'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rx_ovf_q <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (addr_ok && fifo_full && !pop) rx_ovf_q <= 1'b1;
        end
    end

`ifdef LOCAL_NI_STATS_EN
    logic [15:0] tx_pkt_cnt_q, rx_pkt_cnt_q, rx_err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_pkt_cnt_q <= 16'd0;
            rx_pkt_cnt_q <= 16'd0;
            rx_err_cnt_q <= 16'd0;
        end else begin
            if (tx_pkt_done && tx_pkt_cnt_q != 16'hFFFF) tx_pkt_cnt_q <= tx_pkt_cnt_q + 16'd1;
            if (rx_pkt_done && rx_pkt_cnt_q != 16'hFFFF) rx_pkt_cnt_q <= rx_pkt_cnt_q + 16'd1;
            if (rx_err && rx_err_cnt_q != 16'hFFFF)      rx_err_cnt_q <= rx_err_cnt_q + 16'd1;
        end
    end

    assign tx_pkt_cnt = tx_pkt_cnt_q;
    assign rx_pkt_cnt = rx_pkt_cnt_q;
    assign rx_err_cnt = rx_err_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ^{tx_pkt_done, rx_pkt_done, rx_err};
    assign tx_pkt_cnt   = 16'd0;
    assign rx_pkt_cnt   = 16'd0;
    assign rx_err_cnt   = 16'd0;
`endif
endmodule

// File: tb/tb_local_net_interface.sv
// tb/tb_local_net_interface.sv - randomized self-checking bench for local_net_interface
module tb_local_net_interface;
    localparam int         MAX_LEN  = 16;
    localparam int         RX_DEPTH = 4;
    localparam logic [2:0] NODE     = 3'd1;
`ifdef LOCAL_NI_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

    logic clk = 1'b0, rst = 1'b1;
    logic tx_valid = 0, tx_ready, tx_last = 0;
    logic [2:0] tx_dst = 0;
    logic [23:0] tx_data = 0;
    logic [31:0] NI_DATA_OUT, NI_DATA_IN = 0;
    logic NI_DATA_VALID_OUT, NI_FULL_IN = 0, NI_DATA_VALID_IN = 0;
    logic rx_valid, rx_ready = 0;
    logic [23:0] rx_data;
    logic [2:0] rx_src;
    logic [1:0] rx_type;
    logic tx_len_err, rx_ovf;
    logic [15:0] tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt;

    local_net_interface #(.NODE_ADDRESS(NODE), .MAX_LEN(MAX_LEN), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst(tx_dst),
        .tx_data(tx_data), .tx_last(tx_last), .NI_DATA_OUT(NI_DATA_OUT),
        .NI_DATA_VALID_OUT(NI_DATA_VALID_OUT), .NI_FULL_IN(NI_FULL_IN), .NI_DATA_IN(NI_DATA_IN),
        .NI_DATA_VALID_IN(NI_DATA_VALID_IN), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_src(rx_src), .rx_type(rx_type), .tx_len_err(tx_len_err),
        .rx_ovf(rx_ovf), .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .rx_err_cnt(rx_err_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0;

    // Reference model: flits expected at the router, entries expected in the ejection buffer
    logic [31:0] txq[$];
    logic [31:0] tx_seen[$];
    logic [28:0] rxq[$];
    int  pkt_pos;
    logic [2:0] pkt_dst;
    bit  open_pkt [8];
    int  m_tx_pkt, m_rx_pkt, m_rx_err;
    bit  m_len_err, m_ovf;

    function automatic logic [31:0] mk(input logic [2:0] dst, input logic [2:0] src,
                                       input logic [1:0] ty, input logic [23:0] p);
        return {p, ty, src, dst};
    endfunction

    function automatic logic [15:0] sat(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic model_clear();
        txq.delete(); tx_seen.delete(); rxq.delete();
        pkt_pos = 0; pkt_dst = 0;
        foreach (open_pkt[i]) open_pkt[i] = 1'b0;
        m_tx_pkt = 0; m_rx_pkt = 0; m_rx_err = 0; m_len_err = 0; m_ovf = 0;
    endtask

    task automatic model_tx_beat(input logic [2:0] d, input logic [23:0] p, input bit last);
        bit ends;
        logic [1:0] ty;
        if (pkt_pos == 0) pkt_dst = d;
        ends = last || (pkt_pos == MAX_LEN - 1);
        if (pkt_pos == 0) ty = ends ? T_SINGLE : T_HEAD;
        else              ty = ends ? T_TAIL : T_BODY;
        txq.push_back(mk(pkt_dst, NODE, ty, p));
        if (ends) begin
            m_tx_pkt++;
            if (!last) m_len_err = 1'b1;
            pkt_pos = 0;
        end else begin
            pkt_pos++;
        end
    endtask

    task automatic model_rx_flit(input logic [31:0] f);
        logic [2:0] s;
        bit err;
        s = f[5:3];
        err = 1'b0;
        if (f[2:0] != NODE) begin
            m_rx_err++;
            return;
        end
        case (f[7:6])
            T_HEAD: begin err = open_pkt[s]; open_pkt[s] = 1'b1; end
            T_BODY: err = !open_pkt[s];
            T_TAIL: if (open_pkt[s]) begin open_pkt[s] = 1'b0; m_rx_pkt++; end else err = 1'b1;
            default: if (open_pkt[s]) err = 1'b1; else m_rx_pkt++;
        endcase
        if (err) m_rx_err++;
        if (rxq.size() < RX_DEPTH) rxq.push_back({f[31:8], f[5:3], f[7:6]});
        else m_ovf = 1'b1;
    endtask

    task automatic step(input bit tv, input logic [2:0] td, input logic [23:0] tdat, input bit tl,
                        input bit full, input bit rv, input logic [31:0] rf, input bit rr,
                        output bit acc);
        bit exp_rdy, exp_v, pop_e;
        @(posedge clk); #2;
        tx_valid = tv; tx_dst = td; tx_data = tdat; tx_last = tl; NI_FULL_IN = full;
        NI_DATA_VALID_IN = rv; NI_DATA_IN = rf; rx_ready = rr;
        @(negedge clk);
        exp_rdy = (txq.size() == 0) || !full;
        exp_v   = (txq.size() != 0) && !full;
        n_total++; if (tx_ready !== exp_rdy) $display("FAIL tx_ready: got %b want %b", tx_ready, exp_rdy); else n_pass++;
        n_total++; if (NI_DATA_VALID_OUT !== exp_v) $display("FAIL ni_valid: got %b want %b", NI_DATA_VALID_OUT, exp_v); else n_pass++;
        n_total++;
        if (NI_DATA_OUT !== ((txq.size() != 0) ? txq[0] : 32'd0))
            $display("FAIL ni_data: got %h want %h", NI_DATA_OUT, (txq.size() != 0) ? txq[0] : 32'd0);
        else n_pass++;
        if (NI_DATA_VALID_OUT === 1'b1) tx_seen.push_back(NI_DATA_OUT);
        if (exp_v) void'(txq.pop_front());
        acc = tv && exp_rdy;
        if (acc) model_tx_beat(td, tdat, tl);
        n_total++; if (rx_valid !== (rxq.size() != 0)) $display("FAIL rx_valid: got %b want %b", rx_valid, rxq.size() != 0); else n_pass++;
        if (rxq.size() != 0) begin
            n_total++;
            if ({rx_data, rx_src, rx_type} !== rxq[0])
                $display("FAIL rx_head: got %h want %h", {rx_data, rx_src, rx_type}, rxq[0]);
            else n_pass++;
        end
        pop_e = (rxq.size() != 0) && rr;
        if (pop_e) void'(rxq.pop_front());
        if (rv) model_rx_flit(rf);
    endtask

    task automatic idle(input int n, input bit rr);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, rr, a);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1; tx_valid = 0; NI_DATA_VALID_IN = 0; NI_FULL_IN = 0; rx_ready = 0;
        @(posedge clk); @(posedge clk); #2;
        rst = 0;
        model_clear();
    endtask

    task automatic test_reset();
        bit a;
        do_reset();
        step(1, 3'd2, 24'h111111, 0, 1, 1, mk(NODE, 3'd4, T_SINGLE, 24'h222222), 0, a);
        step(0, 0, 0, 0, 1, 0, 0, 0, a);
        @(posedge clk); #2;
        rst = 1; tx_valid = 0; NI_DATA_VALID_IN = 0; NI_FULL_IN = 0;
        @(posedge clk); @(negedge clk);
        n_total++; if (tx_ready !== 1'b0) $display("FAIL rst_tx_ready: got %b want 0", tx_ready); else n_pass++;
        n_total++; if (NI_DATA_VALID_OUT !== 1'b0) $display("FAIL rst_ni_valid: got %b want 0", NI_DATA_VALID_OUT); else n_pass++;
        n_total++; if (NI_DATA_OUT !== 32'd0) $display("FAIL rst_ni_data: got %h want 0", NI_DATA_OUT); else n_pass++;
        n_total++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", rx_valid); else n_pass++;
        n_total++; if ({tx_len_err, rx_ovf} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {tx_len_err, rx_ovf}); else n_pass++;
        n_total++;
        if ({tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt} !== 48'd0)
            $display("FAIL rst_counters: got %h want 0", {tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt});
        else n_pass++;
        #2 rst = 0;
        model_clear();
    endtask

    task automatic test_single();
        bit a;
        do_reset();
        step(1, 3'd5, 24'hABCDEF, 1, 0, 0, 0, 0, a);
        @(posedge clk); #2;
        tx_valid = 0;
        @(negedge clk);
        n_total++; if (NI_DATA_VALID_OUT !== 1'b1) $display("FAIL single_valid: got %b want 1", NI_DATA_VALID_OUT); else n_pass++;
        n_total++; if (NI_DATA_OUT !== 32'hABCDEFCD) $display("FAIL single_flit: got %h want abcdefcd", NI_DATA_OUT); else n_pass++;
        void'(txq.pop_front());
        idle(1, 0);
        n_total++;
        if (tx_pkt_cnt !== (STATS ? 16'd1 : 16'd0)) $display("FAIL single_cnt: got %0d want %0d", tx_pkt_cnt, STATS ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit a;
        int beat, cyc;
        do_reset();
        beat = 0; cyc = 0;
        while (cyc < 20 && (beat < 4 || txq.size() != 0)) begin
            step(beat < 4, 3'd2, 24'h500 + 24'(beat), beat == 3, (cyc >= 1 && cyc <= 3),
                 0, 0, 0, a);
            if (a) beat++;
            cyc++;
        end
        n_total++; if (tx_seen.size() !== 4) $display("FAIL stall_count: got %0d want 4", tx_seen.size()); else n_pass++;
        if (tx_seen.size() == 4) begin
            n_total++;
            if ({tx_seen[0][7:6], tx_seen[1][7:6], tx_seen[2][7:6], tx_seen[3][7:6]} !== 8'b01_00_00_10)
                $display("FAIL stall_types: got %b%b%b%b want 01000010", tx_seen[0][7:6], tx_seen[1][7:6], tx_seen[2][7:6], tx_seen[3][7:6]);
            else n_pass++;
        end
    endtask

    task automatic test_max_len();
        bit a;
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 3'd3, 24'(i), 0, 0, 0, 0, 0, a);
        step(1, 3'd3, 24'hFFFFFF, 1, 0, 0, 0, 0, a);
        idle(2, 0);
        n_total++; if (tx_len_err !== 1'b1) $display("FAIL len_err: got %b want 1", tx_len_err); else n_pass++;
        if (tx_seen.size() >= 17) begin
            n_total++; if (tx_seen[15][7:6] !== T_TAIL) $display("FAIL flit16_type: got %b want 10", tx_seen[15][7:6]); else n_pass++;
            n_total++; if (tx_seen[16][7:6] !== T_HEAD) $display("FAIL flit17_type: got %b want 01", tx_seen[16][7:6]); else n_pass++;
        end else begin
            n_total++; $display("FAIL max_len_flits: got %0d want 21", tx_seen.size());
        end
        n_total++;
        if (tx_pkt_cnt !== (STATS ? 16'd2 : 16'd0)) $display("FAIL max_len_cnt: got %0d want %0d", tx_pkt_cnt, STATS ? 2 : 0);
        else n_pass++;
    endtask

    task automatic test_interleave();
        bit a;
        do_reset();
        step(0, 0, 0, 0, 0, 1, mk(NODE, 3'd2, T_HEAD, 24'hA0), 1, a);
        step(0, 0, 0, 0, 0, 1, mk(NODE, 3'd6, T_HEAD, 24'hB0), 1, a);
        step(0, 0, 0, 0, 0, 1, mk(NODE, 3'd2, T_TAIL, 24'hA1), 1, a);
        step(0, 0, 0, 0, 0, 1, mk(NODE, 3'd6, T_TAIL, 24'hB1), 1, a);
        idle(2, 1);
        n_total++; if (rx_pkt_cnt !== (STATS ? 16'd2 : 16'd0)) $display("FAIL ilv_pkt: got %0d want %0d", rx_pkt_cnt, STATS ? 2 : 0); else n_pass++;
        n_total++; if (rx_err_cnt !== 16'd0) $display("FAIL ilv_err: got %0d want 0", rx_err_cnt); else n_pass++;
    endtask

    task automatic test_addr_frame();
        bit a;
        do_reset();
        step(0, 0, 0, 0, 0, 1, mk(3'd3, 3'd2, T_SINGLE, 24'hC0), 0, a);
        idle(1, 0);
        n_total++; if (rx_valid !== 1'b0) $display("FAIL addr_drop: got %b want 0", rx_valid); else n_pass++;
        n_total++; if (rx_err_cnt !== (STATS ? 16'd1 : 16'd0)) $display("FAIL addr_err: got %0d want %0d", rx_err_cnt, STATS ? 1 : 0); else n_pass++;
        step(0, 0, 0, 0, 0, 1, mk(NODE, 3'd4, T_BODY, 24'hC1), 0, a);
        idle(1, 0);
        n_total++; if (rx_valid !== 1'b1) $display("FAIL body_push: got %b want 1", rx_valid); else n_pass++;
        n_total++; if (rx_err_cnt !== (STATS ? 16'd2 : 16'd0)) $display("FAIL body_err: got %0d want %0d", rx_err_cnt, STATS ? 2 : 0); else n_pass++;
        idle(2, 1);
    endtask

    task automatic test_overflow();
        bit a;
        do_reset();
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, 0, 0, 1, mk(NODE, 3'(i), T_SINGLE, 24'h900 + 24'(i)), 0, a);
        idle(1, 0);
        n_total++; if (rx_ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", rx_ovf); else n_pass++;
        n_total++; if (rxq.size() !== RX_DEPTH) $display("FAIL ovf_model_depth: got %0d want %0d", rxq.size(), RX_DEPTH); else n_pass++;
        n_total++; if (rx_data !== 24'h900) $display("FAIL ovf_head: got %h want 000900", rx_data); else n_pass++;
        n_total++; if (rx_pkt_cnt !== (STATS ? 16'd6 : 16'd0)) $display("FAIL ovf_pkt: got %0d want %0d", rx_pkt_cnt, STATS ? 6 : 0); else n_pass++;
        idle(5, 1);
        n_total++; if (rx_valid !== 1'b0) $display("FAIL ovf_drain: got %b want 0", rx_valid); else n_pass++;
    endtask

    task automatic test_random();
        bit a;
        logic [2:0] d;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 3'($urandom) : NODE;
            step($urandom_range(0, 3) != 0, 3'($urandom), 24'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                 mk(d, 3'($urandom), 2'($urandom), 24'($urandom)), $urandom_range(0, 2) != 0, a);
        end
        idle(RX_DEPTH + 2, 1);
        n_total++; if (tx_len_err !== m_len_err) $display("FAIL rnd_len_err: got %b want %b", tx_len_err, m_len_err); else n_pass++;
        n_total++; if (rx_ovf !== m_ovf) $display("FAIL rnd_ovf: got %b want %b", rx_ovf, m_ovf); else n_pass++;
        n_total++; if (tx_pkt_cnt !== (STATS ? sat(m_tx_pkt) : 16'd0)) $display("FAIL rnd_tx_cnt: got %0d want %0d", tx_pkt_cnt, STATS ? m_tx_pkt : 0); else n_pass++;
        n_total++; if (rx_pkt_cnt !== (STATS ? sat(m_rx_pkt) : 16'd0)) $display("FAIL rnd_rx_cnt: got %0d want %0d", rx_pkt_cnt, STATS ? m_rx_pkt : 0); else n_pass++;
        n_total++; if (rx_err_cnt !== (STATS ? sat(m_rx_err) : 16'd0)) $display("FAIL rnd_err_cnt: got %0d want %0d", rx_err_cnt, STATS ? m_rx_err : 0); else n_pass++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_stall();
        test_max_len();
        test_interleave();
        test_addr_frame();
        test_overflow();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
